// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: sizes, FSM encoding and a
// pointer-width helper used by the top and the round-robin arbiter.
package dmem_pkg;

  localparam int DMEM_ADDR_W = 12;
  localparam int DMEM_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } dmem_state_t;

  // Width of a port index; never zero, even for a degenerate single port.
  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: the first requesting port at or after ptr,
// wrapping modulo NUM_REQ, as a one-hot grant plus its index.
module rr_arbiter
  import dmem_pkg::*;
#(
  parameter  int NUM_REQ = 2,
  localparam int PTR_W   = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   grant_idx,
  output logic               valid
);

  logic             found;
  logic [PTR_W-1:0] cand;

  always_comb begin
    // NOTE: every output and temporary gets a default first so no latch is inferred.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = PTR_W'((int'(ptr) + i) % NUM_REQ);
      if (!found && req[cand]) begin
        found       = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

  assign valid = |req;

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin sequencer sharing one single-port data memory among NUM_REQ
// requesters: IDLE -> ISSUE -> CAPTURE -> DONE, one access per four cycles.
module data_mem_arbiter
  import dmem_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = DMEM_ADDR_W,
  parameter int DATA_W  = DMEM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        we,
  input  logic [NUM_REQ*ADDR_W-1:0] addr,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      busy,
  output logic                      mem_read_ctrl,
  output logic                      mem_write_ctrl,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [DATA_W-1:0]         mem_data_write,
  input  logic [DATA_W-1:0]         mem_data_read
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  dmem_state_t        state, state_nxt;
  logic [PTR_W-1:0]   ptr, owner, grant_idx;
  logic [NUM_REQ-1:0] grant;
  logic               grant_valid;
  logic               grant_we;
  logic               owner_we;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .req       (req),
    .ptr       (ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .valid     (grant_valid)
  );

  assign grant_we = |(we & grant);

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_valid) state_nxt = ISSUE;
      ISSUE:   state_nxt = CAPTURE;
      CAPTURE: state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Controls are registered: high for exactly the ISSUE cycle, and mutually exclusive.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner          <= '0;
      owner_we       <= 1'b0;
      ptr            <= '0;
      mem_read_ctrl  <= 1'b0;
      mem_write_ctrl <= 1'b0;
      mem_address    <= '0;
      mem_data_write <= '0;
      rdata          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_valid) begin
            owner          <= grant_idx;
            owner_we       <= grant_we;
            mem_address    <= addr[grant_idx*ADDR_W +: ADDR_W];
            mem_data_write <= wdata[grant_idx*DATA_W +: DATA_W];
            mem_write_ctrl <= grant_we;
            mem_read_ctrl  <= ~grant_we;
          end
        end
        ISSUE: begin
          mem_read_ctrl  <= 1'b0;
          mem_write_ctrl <= 1'b0;
        end
        CAPTURE: begin
          if (!owner_we) rdata <= mem_data_read;
        end
        DONE: begin
          ptr <= (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done = '0;
    if (state == DONE) done[owner] = 1'b1;
  end

  assign busy = (state != IDLE);

endmodule
